// File: rtl/cms_pix28_cmd_if.sv
// Host-side command/read-back channel of the pix28 command decoder.
// Both directions use valid/ready: a word transfers on a rising edge where valid && ready, and the sender keeps valid and the word stable until then.
interface cms_pix28_cmd_if;
  logic        cmd_valid;
  logic [31:0] cmd_word;
  logic        cmd_ready;
  logic        rd_valid;
  logic [31:0] rd_word;
  logic        rd_ready;

  modport master (
    output cmd_valid, cmd_word, rd_ready,
    input  cmd_ready, rd_valid, rd_word
  );

  modport slave (
    input  cmd_valid, cmd_word, rd_ready,
    output cmd_ready, rd_valid, rd_word
  );
endinterface

// File: rtl/cms_pix28_cmd_decoder.sv
// Front-end command decoder for the pix28 firmware: decodes host command words,
// holds static config, fires execute/array/reset strobes and keeps the sticky status word.
module cms_pix28_cmd_decoder #(
  parameter logic [3:0] FW_ID      = 4'h1,
  parameter int         RST_CYCLES = 8
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst_n,
  cms_pix28_cmd_if.slave host,
  output logic [23:0] cfg_static_0,
  output logic [23:0] cfg_static_1,
  output logic [23:0] exec_cfg,
  output logic        exec_start,
  input  logic        test_busy,
  input  logic [3:0]  test_done,
  output logic [2:0]  arr_wr_en,
  output logic [4:0]  arr_rd_req,
  output logic [23:0] arr_addr_data,
  input  logic        arr_rd_valid,
  input  logic [23:0] arr_rd_data,
  output logic        fw_rst_pulse,
  output logic [31:0] status,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] OP_NOOP           = 4'h0;
  localparam logic [3:0] OP_W_RST_FW       = 4'h1;
  localparam logic [3:0] OP_W_CFG_STATIC_0 = 4'h2;
  localparam logic [3:0] OP_R_CFG_STATIC_0 = 4'h3;
  localparam logic [3:0] OP_W_CFG_STATIC_1 = 4'h4;
  localparam logic [3:0] OP_R_CFG_STATIC_1 = 4'h5;
  localparam logic [3:0] OP_W_CFG_ARRAY_0  = 4'h6;
  localparam logic [3:0] OP_R_CFG_ARRAY_0  = 4'h7;
  localparam logic [3:0] OP_W_CFG_ARRAY_1  = 4'h8;
  localparam logic [3:0] OP_R_CFG_ARRAY_1  = 4'h9;
  localparam logic [3:0] OP_W_CFG_ARRAY_2  = 4'hA;
  localparam logic [3:0] OP_R_CFG_ARRAY_2  = 4'hB;
  localparam logic [3:0] OP_R_DATA_ARRAY_0 = 4'hC;
  localparam logic [3:0] OP_R_DATA_ARRAY_1 = 4'hD;
  localparam logic [3:0] OP_W_STATUS_CLEAR = 4'hE;
  localparam logic [3:0] OP_W_EXECUTE      = 4'hF;

  localparam logic [3:0] FIRMWARE_ID_2 = 4'h2;
  localparam int         CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_RD_RESP, S_ARR_WAIT, S_RST_HOLD
  } state_t;

  state_t        state, state_n;
  logic [31:0]   cmd_q;
  logic [31:0]   rd_word_q;
  logic [CW-1:0] rst_cnt;

  logic [3:0]  op;
  logic [23:0] body;
  logic [3:0]  test_num;
  logic        cmd_hit, test_num_ok;
  logic        do_rst, do_wcfg0, do_wcfg1, do_clear, exec_ok, arr_op;
  logic        rd_load_static, rd_load_arr;
  logic [2:0]  arr_wr_n;
  logic [4:0]  arr_rd_n;
  logic [31:0] set_bits, status_n;

  assign op   = cmd_q[27:24];
  assign body = cmd_q[23:0];

  assign host.cmd_ready = (state == S_IDLE);
  assign host.rd_valid  = (state == S_RD_RESP);
  assign host.rd_word   = rd_word_q;
  assign dbg_state      = state;

  always_ff @(posedge fw_axi_clk) begin
    if (!fw_rst_n) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n        = state;
    cmd_hit        = (cmd_q[31:28] == FW_ID) && (op != OP_NOOP);
    test_num       = (FW_ID == FIRMWARE_ID_2) ? body[15:12] : body[17:14];
    test_num_ok    = 1'b0;
    do_rst         = 1'b0;
    do_wcfg0       = 1'b0;
    do_wcfg1       = 1'b0;
    do_clear       = 1'b0;
    exec_ok        = 1'b0;
    arr_op         = 1'b0;
    rd_load_static = 1'b0;
    rd_load_arr    = 1'b0;
    arr_wr_n       = 3'b000;
    arr_rd_n       = 5'b00000;
    set_bits       = 32'h0;

    case (test_num)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd8: test_num_ok = 1'b1;
      default:                      test_num_ok = 1'b0;
    endcase

    case (state)
      S_IDLE: if (host.cmd_valid) state_n = S_DECODE;
      S_DECODE: begin
        state_n = S_IDLE;
        if (cmd_hit) begin
          // Ops 1..13 each own the status bit one below their opcode.
          if (op <= OP_R_DATA_ARRAY_1) set_bits[op - 4'd1] = 1'b1;
          case (op)
            OP_W_RST_FW:       begin do_rst = 1'b1; state_n = S_RST_HOLD; end
            OP_W_CFG_STATIC_0: do_wcfg0 = 1'b1;
            OP_W_CFG_STATIC_1: do_wcfg1 = 1'b1;
            OP_R_CFG_STATIC_0,
            OP_R_CFG_STATIC_1: begin rd_load_static = 1'b1; state_n = S_RD_RESP; end
            OP_W_CFG_ARRAY_0:  begin arr_op = 1'b1; arr_wr_n = 3'b001; end
            OP_W_CFG_ARRAY_1:  begin arr_op = 1'b1; arr_wr_n = 3'b010; end
            OP_W_CFG_ARRAY_2:  begin arr_op = 1'b1; arr_wr_n = 3'b100; end
            OP_R_CFG_ARRAY_0:  begin arr_op = 1'b1; arr_rd_n = 5'b00001; state_n = S_ARR_WAIT; end
            OP_R_CFG_ARRAY_1:  begin arr_op = 1'b1; arr_rd_n = 5'b00010; state_n = S_ARR_WAIT; end
            OP_R_CFG_ARRAY_2:  begin arr_op = 1'b1; arr_rd_n = 5'b00100; state_n = S_ARR_WAIT; end
            OP_R_DATA_ARRAY_0: begin arr_op = 1'b1; arr_rd_n = 5'b01000; state_n = S_ARR_WAIT; end
            OP_R_DATA_ARRAY_1: begin arr_op = 1'b1; arr_rd_n = 5'b10000; state_n = S_ARR_WAIT; end
            OP_W_STATUS_CLEAR: do_clear = 1'b1;
            OP_W_EXECUTE: begin
              if (test_busy || !test_num_ok) set_bits[31] = 1'b1;
              else begin exec_ok = 1'b1; set_bits[13] = 1'b1; end
            end
            default: state_n = S_IDLE;
          endcase
        end
      end
      S_ARR_WAIT: if (arr_rd_valid) begin rd_load_arr = 1'b1; state_n = S_RD_RESP; end
      S_RD_RESP:  if (host.rd_ready) state_n = S_IDLE;
      S_RST_HOLD: if (rst_cnt == '0) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase

    // Set beats clear: fresh bits and test_done pulses land on top of a clear.
    status_n          = (do_clear || do_rst) ? 32'h0 : status;
    status_n          = status_n | set_bits;
    status_n[17:14]   = status_n[17:14] | test_done;
  end

  always_ff @(posedge fw_axi_clk) begin
    if (!fw_rst_n) begin
      cmd_q         <= 32'h0;
      rd_word_q     <= 32'h0;
      cfg_static_0  <= 24'h0;
      cfg_static_1  <= 24'h0;
      exec_cfg      <= 24'h0;
      exec_start    <= 1'b0;
      arr_wr_en     <= 3'b000;
      arr_rd_req    <= 5'b00000;
      arr_addr_data <= 24'h0;
      fw_rst_pulse  <= 1'b0;
      rst_cnt       <= '0;
      status        <= 32'h0;
    end else begin
      exec_start <= exec_ok;
      arr_wr_en  <= arr_wr_n;
      arr_rd_req <= arr_rd_n;
      status     <= status_n;
      if (state == S_IDLE && host.cmd_valid) cmd_q <= host.cmd_word;
      if (do_rst) begin
        cfg_static_0 <= 24'h0;
        cfg_static_1 <= 24'h0;
        exec_cfg     <= 24'h0;
      end
      if (do_wcfg0) cfg_static_0 <= body;
      if (do_wcfg1) cfg_static_1 <= body;
      if (exec_ok)  exec_cfg     <= body;
      if (arr_op)   arr_addr_data <= body;
      if (rd_load_static)
        rd_word_q <= {cmd_q[31:24], (op == OP_R_CFG_STATIC_1) ? cfg_static_1 : cfg_static_0};
      if (rd_load_arr)
        rd_word_q <= {cmd_q[31:24], arr_rd_data};
      // Pulse rises with the decode and drops on the edge the counter is seen at zero.
      if (do_rst) begin
        fw_rst_pulse <= 1'b1;
        rst_cnt      <= CW'(RST_CYCLES - 1);
      end else if (state == S_RST_HOLD) begin
        if (rst_cnt == '0) fw_rst_pulse <= 1'b0;
        else               rst_cnt      <= rst_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cms_pix28_cmd_decoder.sv
// Directed bench for cms_pix28_cmd_decoder (FW_ID=1, RST_CYCLES=8) with immediate-assertion checks.
module tb_cms_pix28_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] cfg_static_0, cfg_static_1, exec_cfg, arr_addr_data, arr_rd_data;
  logic        exec_start, test_busy, arr_rd_valid, fw_rst_pulse;
  logic [3:0]  test_done;
  logic [2:0]  arr_wr_en, dbg_state;
  logic [4:0]  arr_rd_req;
  logic [31:0] status;
  int          n_tests = 0;
  int          n_fail  = 0;

  cms_pix28_cmd_if bus ();

  cms_pix28_cmd_decoder #(.FW_ID(4'h1), .RST_CYCLES(8)) dut (
    .fw_axi_clk    (clk),
    .fw_rst_n      (rst_n),
    .host          (bus),
    .cfg_static_0  (cfg_static_0),
    .cfg_static_1  (cfg_static_1),
    .exec_cfg      (exec_cfg),
    .exec_start    (exec_start),
    .test_busy     (test_busy),
    .test_done     (test_done),
    .arr_wr_en     (arr_wr_en),
    .arr_rd_req    (arr_rd_req),
    .arr_addr_data (arr_addr_data),
    .arr_rd_valid  (arr_rd_valid),
    .arr_rd_data   (arr_rd_data),
    .fw_rst_pulse  (fw_rst_pulse),
    .status        (status),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] w);
    int k = 0;
    while (!bus.cmd_ready && k < 50) begin tick(); k++; end
    if (!bus.cmd_ready) check("send_ready_timeout", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_word  = w;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_word  = 32'h0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_word = 32'h0; bus.rd_ready = 1'b0;
    test_busy = 1'b0; test_done = 4'h0; arr_rd_valid = 1'b0; arr_rd_data = 24'h0;
    repeat (3) tick();

    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_status", status, 32'h0);
    check("rst_cfg0", 32'(cfg_static_0), 32'h0);
    check("rst_strobes", {25'h0, exec_start, fw_rst_pulse, arr_wr_en, arr_rd_req[1:0]}, 32'h0);
    rst_n = 1'b1;
    tick();

    // T1: write then read back cfg_static_0
    send(32'h1200ABCD);
    tick();
    check("t1_cfg0", 32'(cfg_static_0), 32'h0000ABCD);
    check("t1_status_w", status, 32'h2);
    check("t1_ready_back", 32'(bus.cmd_ready), 32'd1);
    send(32'h13000000);
    tick();
    check("t1_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("t1_rd_word", bus.rd_word, 32'h1300ABCD);
    check("t1_status_r", status, 32'h6);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("t1_rd_done", 32'(bus.rd_valid), 32'd0);

    // T2: foreign device id is dropped
    send(32'h2200FFFF);
    tick();
    check("t2_cfg0", 32'(cfg_static_0), 32'h0000ABCD);
    check("t2_status", status, 32'h6);
    check("t2_ready", 32'(bus.cmd_ready), 32'd1);

    // cfg_static_1 write and read
    send(32'h14001234);
    tick();
    check("cfg1_w", 32'(cfg_static_1), 32'h00001234);
    send(32'h15000000);
    tick();
    check("cfg1_rd_word", bus.rd_word, 32'h15001234);
    check("cfg1_status", status, 32'h1E);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;

    // T3: execute test 1, then while busy
    send(32'h1F004000);
    tick();
    check("t3_start", 32'(exec_start), 32'd1);
    check("t3_exec_cfg", 32'(exec_cfg), 32'h00004000);
    check("t3_status", status, 32'h201E);
    tick();
    check("t3_start_1cyc", 32'(exec_start), 32'd0);
    test_busy = 1'b1;
    send(32'h1F008000);
    tick();
    test_busy = 1'b0;
    check("t3_busy_nostart", 32'(exec_start), 32'd0);
    check("t3_busy_cfg", 32'(exec_cfg), 32'h00004000);
    check("t3_busy_status", status, 32'h8000201E);

    // Clear, then invalid test number 5, then valid test 3
    send(32'h1E000000);
    tick();
    check("clr_status", status, 32'h0);
    send(32'h1F014000);
    tick();
    check("t5num_nostart", 32'(exec_start), 32'd0);
    check("t5num_status", status, 32'h80000000);
    send(32'h1F00C000);
    tick();
    check("t3num_start", 32'(exec_start), 32'd1);
    check("t3num_cfg", 32'(exec_cfg), 32'h0000C000);
    check("t3num_status", status, 32'h80002000);

    // T4: cfg array 0 read, data arrives 3 cycles later, host stalls 4 cycles
    send(32'h17000005);
    tick();
    check("t4_rd_req", 32'(arr_rd_req), 32'h1);
    check("t4_addr", 32'(arr_addr_data), 32'h5);
    tick();
    check("t4_rd_req_1cyc", 32'(arr_rd_req), 32'h0);
    check("t4_wait_no_valid", 32'(bus.rd_valid), 32'd0);
    tick();
    arr_rd_valid = 1'b1; arr_rd_data = 24'h123456;
    tick();
    arr_rd_valid = 1'b0; arr_rd_data = 24'h0;
    for (int i = 0; i < 4; i++) begin
      check("t4_hold_valid", 32'(bus.rd_valid), 32'd1);
      check("t4_hold_word", bus.rd_word, 32'h17123456);
      tick();
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("t4_rd_done", 32'(bus.rd_valid), 32'd0);
    check("t4_status", status, 32'h80002040);

    // cfg array 2 write strobe
    send(32'h1A0000AA);
    tick();
    check("warr_en", 32'(arr_wr_en), 32'h4);
    check("warr_data", 32'(arr_addr_data), 32'hAA);
    tick();
    check("warr_en_1cyc", 32'(arr_wr_en), 32'h0);
    check("warr_status", status, 32'h80002240);

    // data array 1 read
    send(32'h1D000010);
    tick();
    check("darr_req", 32'(arr_rd_req), 32'h10);
    arr_rd_valid = 1'b1; arr_rd_data = 24'hABCDEF;
    tick();
    arr_rd_valid = 1'b0;
    check("darr_word", bus.rd_word, 32'h1DABCDEF);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("darr_status", status, 32'h80003240);

    // T5: firmware reset pulse width
    send(32'h11000000);
    tick();
    check("t5_cfg0", 32'(cfg_static_0), 32'h0);
    check("t5_cfg1", 32'(cfg_static_1), 32'h0);
    check("t5_exec_cfg", 32'(exec_cfg), 32'h0);
    check("t5_status", status, 32'h1);
    cnt = 0;
    while (fw_rst_pulse && cnt < 20) begin
      check("t5_ready_low", 32'(bus.cmd_ready), 32'd0);
      cnt++;
      tick();
    end
    check("t5_pulse_width", 32'(cnt), 32'd8);
    check("t5_ready_after", 32'(bus.cmd_ready), 32'd1);

    // T6: test_done coincident with clear wins, then idle test_done
    send(32'h1E000000);
    test_done = 4'b0010;
    tick();
    test_done = 4'h0;
    check("t6_clear_set", status, 32'h00008000);
    test_done = 4'b1000;
    tick();
    test_done = 4'h0;
    check("t6_idle_done", status, 32'h00028000);

    // Reset during RD_RESP
    send(32'h13000000);
    tick();
    check("t6_rd_valid", 32'(bus.rd_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t6_rst_status", status, 32'h0);
    check("t6_rst_ready", 32'(bus.cmd_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
